piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in, serial-out framing transmitter that sits directly upstream of the 4-bit serial-in shift register and drives its `din` input. It accepts a W-bit word through a valid/ready handshake. It then emits the word as a framed serial stream, one bit per `clk` cycle: start bit, data bits, optional parity bit, stop bit. Back-to-back words can be sent without idle gaps, so the downstream shift register sees a continuous, well-defined bit stream.

## Interface
- `W`, default 4: data word width; must be ≥2.
- `MSB_FIRST`, default 1: 1 sends bit W-1 first; 0 sends bit 0 first.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `res`  in  1  reset; synchronous, active-high.
- `din`  in  W  parallel word; sampled only on an accepting edge.
- `valid`  in  1  `din` holds a word to send.
- `ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial line; connects to the shift register's `din`.
- `frame`  out  1  high while start, data or parity bits are on `dout`.
- `done`  out  1  one-cycle pulse during the stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Line levels: idle = 0, start = 1, stop = 0.
- Accept condition: `valid && ready` at a rising edge.
  - Captures `din` into the internal shift register.
  - Computes the parity bit.
  - Next state is START.
- `ready` is 1 in IDLE and STOP and 0 in all other states. It is forced to 0 while `res` is high.
- IDLE: `dout` = 0, `frame` = 0. Stays in IDLE until a word is accepted.
- START: `dout` = 1, `frame` = 1. Next state is DATA; bit counter is cleared.
- DATA: `dout` = current data bit, `frame` = 1. Runs for W cycles, with the counter counting 0..W-1. After the last bit, goes to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: `dout` = parity bit, `frame` = 1. Next state is STOP.
  - Even parity: parity bit = XOR of the data bits.
  - Odd parity: parity bit = inverted XOR of the data bits.
- STOP: `dout` = 0, `frame` = 0, `done` = 1. Next state is START if a word is accepted this cycle, otherwise IDLE.
- `valid` while `ready` = 0 is ignored and not queued. Dropping `valid` before acceptance is legal.
- `din` need only be stable in the accepting cycle.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `din` or `valid` to `dout`.
- Reset values: state IDLE, `dout` 0, `frame` 0, `done` 0, `ready` 0 while `res` is high and 1 on the first cycle after.
- Accept at edge k gives this sequence on `dout`:
  - start bit during cycle k+1;
  - data bit i during cycle k+2+i;
  - parity bit during cycle k+2+W (when enabled);
  - stop bit during cycle k+2+W+P, where P = `PARITY_EN`.
- Frame length is W+2+P cycles. With continuous `valid`, the frame period is exactly W+2+P cycles with no idle gap.
- Reset mid-frame: at the next edge, state is IDLE and `dout`, `frame`, `done` are 0. The partial frame is abandoned, no `done` is issued, and the captured word is discarded.
- `res` and `valid` high in the same cycle: reset wins and the word is not accepted.

## Structure
- Shared package `piso_tx_pkg` holds:
  - the state typedef;
  - constants `LINE_IDLE` = 0, `LINE_START` = 1, `LINE_STOP` = 0.
- Bit counter width is $clog2(W).
- One sub-module, `piso_tx_par`: parameterized XOR reduction with odd/even select that produces the parity bit at capture time. Everything else lives in `piso_tx`.

## Test plan
All scenarios use default parameters unless stated.
- Reset: `res` high for 2 cycles → `dout`=0, `frame`=0, `done`=0, `ready`=0; `ready`=1 on the first cycle after `res` falls.
- Single word: `din`=4'b1011 accepted at edge k → `dout` from k+1 is 1,1,0,1,1,1,0. `frame` is high for 6 cycles. `done` is high only in the 7th cycle.
- Back-to-back: 4'hA then 4'h3 with `valid` held → `dout` is 1,1,0,1,0,0,0 then 1,0,0,1,1,0,0 with no gap. The second word is accepted in the first frame's STOP cycle.
- Busy ignore: `valid` with `din`=4'hF asserted during DATA of a 4'h0 frame, then dropped before STOP → 4'h0 frame completes unchanged (1,0,0,0,0,0,0) and 4'hF is never sent.
- Reset mid-frame: `res` pulsed during the 2nd data bit → next cycle `dout`=0, `frame`=0, no `done`. A following word 4'h5 transmits normally as 1,0,1,0,1,0,0.
- Parameter variant: W=8, `MSB_FIRST`=0, `PARITY_ODD`=1, `din`=8'h01 → `dout` is 1,1,0,0,0,0,0,0,0,0,0 (11 cycles, parity bit 0), with `done` in cycle 11.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and line levels for the piso_tx framing transmitter.
package piso_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/piso_tx_par.sv
// Parity generator: XOR reduction of the word, inverted when odd parity is selected.
module piso_tx_par #(
    parameter int W          = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [W-1:0] data,
    output logic         par
);

    always_comb begin
        par = (^data) ^ PARITY_ODD;
    end

endmodule

// File: rtl/piso_tx.sv
// Framing transmitter: accepts a W-bit word on valid/ready and serialises it as
// start bit, data bits, optional parity bit and stop bit, one bit per clock.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int W          = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         res,
    input  logic [W-1:0] din,
    input  logic         valid,
    output logic         ready,
    output logic         dout,
    output logic         frame,
    output logic         done
);

    localparam int              CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             par_w;
    logic             dout_q, dout_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             accept;

    function automatic logic first_bit(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1] : v[0];
    endfunction

    function automatic logic [W-1:0] shift_out(input logic [W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    piso_tx_par #(
        .W          (W),
        .PARITY_ODD (PARITY_ODD)
    ) u_par (
        .data (din),
        .par  (par_w)
    );

    // ready is decoded from registered state; reset blocks acceptance in the same cycle
    always_comb begin
        ready  = ((state_q == ST_IDLE) || (state_q == ST_STOP)) && !res;
        accept = valid && ready;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    sh_d    = din;
                    par_d   = par_w;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sh_d  = shift_out(sh_q);
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (accept) begin
                    state_d = ST_START;
                    sh_d    = din;
                    par_d   = par_w;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        case (state_d)
            ST_START:  dout_d = LINE_START;
            ST_DATA:   dout_d = first_bit(sh_d);
            ST_PARITY: dout_d = par_d;
            ST_STOP:   dout_d = LINE_STOP;
            default:   dout_d = LINE_IDLE;
        endcase
        frame_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_PARITY);
        done_d  = (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            dout_q  <= LINE_IDLE;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // Word, counter and parity are only meaningful while a frame is in flight
    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        cnt_q <= cnt_d;
        par_q <= par_d;
    end

    always_comb begin
        dout  = dout_q;
        frame = frame_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: a default instance and a W=8 LSB-first odd-parity instance.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [3:0] din_a = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, dout_a, frame_a, done_a;
    logic [7:0] din_b = '0;
    logic       valid_b = 1'b0;
    logic       ready_b, dout_b, frame_b, done_b;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    bit acc_a, acc_b;

    // each entry is the expected {dout, frame, done} for one future cycle
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] frm[$];

    always #5 clk = ~clk;

    piso_tx u_a (
        .clk   (clk),
        .res   (res),
        .din   (din_a),
        .valid (valid_a),
        .ready (ready_a),
        .dout  (dout_a),
        .frame (frame_a),
        .done  (done_a)
    );

    piso_tx #(
        .W          (8),
        .MSB_FIRST  (1'b0),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b1)
    ) u_b (
        .clk   (clk),
        .res   (res),
        .din   (din_b),
        .valid (valid_b),
        .ready (ready_b),
        .dout  (dout_b),
        .frame (frame_b),
        .done  (done_b)
    );

    // Builds the line sequence of one frame from the framing rules
    function automatic void build(input int w, input bit msb, input bit odd, input logic [7:0] d);
        logic p;
        frm.delete();
        p = odd;
        frm.push_back(3'b110);
        for (int i = 0; i < w; i++) begin
            logic b;
            b = msb ? d[w-1-i] : d[i];
            p = p ^ b;
            frm.push_back({b, 2'b10});
        end
        frm.push_back({p, 2'b10});
        frm.push_back(3'b001);
    endfunction

    // Reference model evaluated at each rising edge, with the inputs of the ending cycle
    function automatic void model_edge();
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (res) begin
            qa.delete();
            qb.delete();
            mon_en = 1'b1;
        end else begin
            if (valid_a && qa.size() == 0) begin
                acc_a = 1'b1;
                build(4, 1'b1, 1'b0, {4'h0, din_a});
                foreach (frm[i]) qa.push_back(frm[i]);
            end
            if (valid_b && qb.size() == 0) begin
                acc_b = 1'b1;
                build(8, 1'b0, 1'b1, din_b);
                foreach (frm[i]) qb.push_back(frm[i]);
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic va, input logic [3:0] da,
                       input logic vb, input logic [7:0] db);
        res = r;
        valid_a = va;
        din_a = da;
        valid_b = vb;
        din_b = db;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got {dout,frame,done,ready}=%b expected %b", name, $time, act, exp);
        end
    endfunction

    // Monitor: one scoreboard pop per instance per cycle, mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] ea, eb;
            ea = (qa.size() != 0) ? qa.pop_front() : 3'b000;
            eb = (qb.size() != 0) ? qb.pop_front() : 3'b000;
            check("inst_a", {dout_a, frame_a, done_a, ready_a},
                  {ea, ((ea == 3'b000) || (ea == 3'b001)) && !res});
            check("inst_b", {dout_b, frame_b, done_b, ready_b},
                  {eb, ((eb == 3'b000) || (eb == 3'b001)) && !res});
        end
    end

    initial begin
        logic [3:0] words[2];
        int idx;

        // reset held for two cycles
        cyc(1, 0, 4'h0, 0, 8'h00);
        cyc(1, 1, 4'hF, 1, 8'hFF);
        cyc(0, 0, 4'h0, 0, 8'h00);
        cyc(0, 0, 4'h0, 0, 8'h00);

        // single word on A, 8'h01 on B
        cyc(0, 1, 4'b1011, 1, 8'h01);
        for (int i = 0; i < 12; i++) cyc(0, 0, 4'h0, 0, 8'h00);

        // back-to-back A then 3 with valid held
        words[0] = 4'hA;
        words[1] = 4'h3;
        idx = 0;
        for (int i = 0; i < 20 && idx < 2; i++) begin
            cyc(0, 1, words[idx], 0, 8'h00);
            if (acc_a) idx++;
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 4'h0, 0, 8'h00);

        // busy ignore: F offered during DATA of a 0 frame, withdrawn before STOP
        cyc(0, 1, 4'h0, 0, 8'h00);
        cyc(0, 0, 4'h0, 0, 8'h00);
        cyc(0, 1, 4'hF, 0, 8'h00);
        cyc(0, 1, 4'hF, 0, 8'h00);
        cyc(0, 0, 4'h0, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 0, 4'h0, 0, 8'h00);

        // reset pulsed during the second data bit, then 5 sent normally
        cyc(0, 1, 4'h9, 1, 8'hA5);
        cyc(0, 0, 4'h0, 0, 8'h00);
        cyc(0, 0, 4'h0, 0, 8'h00);
        cyc(1, 1, 4'h7, 1, 8'h3C);
        cyc(0, 1, 4'h5, 0, 8'h00);
        for (int i = 0; i < 8; i++) cyc(0, 0, 4'h0, 0, 8'h00);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 4'($urandom),
                ($urandom_range(0, 2) != 0), 8'($urandom));
        end
        for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
